// File: rtl/div_io_ctrl.sv
// Host front end for the integer divider: accepts operand pairs, launches the divider, returns results.
// Latency: go one cycle after accept, result one cycle after done plus one DELIVER cycle; backpressure: holds in DELIVER while the output register is full.
module div_io_ctrl #(
    parameter int WIDTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_go,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    output logic             div_abort,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic [1:0]       out_err,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_r;
    logic [1:0]      cap_err;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_q     <= '0;
            cap_r     <= '0;
            cap_err   <= 2'b00;
            div_go    <= 1'b0;
            div_abort <= 1'b0;
            div_x     <= '0;
            div_y     <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_err   <= 2'b00;
        end else begin
            div_go    <= 1'b0;
            div_abort <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_divisor != '0) begin
                            div_x  <= in_dividend;
                            div_y  <= in_divisor;
                            div_go <= 1'b1;
                            state  <= LAUNCH;
                        end else begin
                            cap_q   <= '1;
                            cap_r   <= in_dividend;
                            cap_err <= 2'b01;
                            state   <= DELIVER;
                        end
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt != CNT_LAST)
                        cnt <= cnt + 1'b1;
                    // done has priority over a timeout landing on the same cycle
                    if (div_done) begin
                        cap_q   <= div_q;
                        cap_r   <= div_r;
                        cap_err <= 2'b00;
                        state   <= DELIVER;
                    end else if (cnt == CNT_LAST) begin
                        cap_q     <= '0;
                        cap_r     <= '0;
                        cap_err   <= 2'b10;
                        div_abort <= 1'b1;
                        state     <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (!out_valid || out_ready) begin
                        out_q     <= cap_q;
                        out_r     <= cap_r;
                        out_err   <= cap_err;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_io_ctrl.md
Name: div_io_ctrl

Overview:
Host-side front end for the integer divider. It accepts dividend/divisor pairs over a valid/ready handshake and launches the divider control unit with a one-cycle go pulse. It captures quotient/remainder on the divider's done pulse and presents results over a valid/ready output port. It also short-circuits divide-by-zero and aborts the divider if done never arrives.

Parameters:
WIDTH, 4, operand/result width in bits
TIMEOUT_CYC, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  request present
in_ready  output  1  request accepted when in_valid && in_ready
in_dividend  input  WIDTH  dividend
in_divisor  input  WIDTH  divisor
div_go  output  1  one-cycle launch pulse to divider control unit
div_x  output  WIDTH  dividend held to divider datapath
div_y  output  WIDTH  divisor held to divider datapath
div_abort  output  1  one-cycle reset pulse to divider on timeout
div_done  input  1  divider done pulse
div_q  input  WIDTH  divider quotient, valid when div_done=1
div_r  input  WIDTH  divider remainder, valid when div_done=1
out_valid  output  1  result present
out_ready  input  1  result consumed when out_valid && out_ready
out_q  output  WIDTH  quotient
out_r  output  WIDTH  remainder
out_err  output  2  00 ok, 01 divide-by-zero, 10 timeout
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; div_go=0, div_abort=0, div_x=0, div_y=0, out_valid=0, out_q=0, out_r=0, out_err=00, timeout counter=0, capture regs=0. in_ready=1 and busy=0 combinationally from IDLE.
- in_ready = (state==IDLE), combinational. It does not depend on out_valid.
- States: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE, on accept with in_divisor!=0: latch div_x/div_y and go to LAUNCH.
- IDLE, on accept with in_divisor==0: capture q=all-ones, r=in_dividend, err=01 and go to DELIVER. The divider is never launched (div_go stays 0).
- LAUNCH: div_go=1 for exactly this cycle and the timeout counter is cleared. Next state is WAIT.
- WAIT: the counter increments each cycle. On div_done=1, capture div_q/div_r with err=00 and go to DELIVER.
- WAIT timeout: if the counter reaches TIMEOUT_CYC-1 with div_done=0, capture q=0, r=0, err=10. div_abort=1 for the next cycle (registered). Go to DELIVER.
- WAIT, simultaneous events: if div_done and timeout occur in the same cycle, done wins and err=00.
- div_x/div_y stay stable from accept until the state next leaves DELIVER.
- div_done is ignored in every state except WAIT. A late done after a timeout is dropped.
- DELIVER: if out_valid==0 or out_ready==1, load the capture regs into out_q/out_r/out_err, set out_valid=1 and return to IDLE. Otherwise hold in DELIVER with the capture regs preserved.
- Output register: out_valid clears on out_valid && out_ready unless reloaded the same edge. Reload wins, and out_valid stays 1 with new data.
- out_q/out_r/out_err are stable while out_valid=1 and out_ready=0.
- Latency with out_ready=1: accept at edge N; div_go high in cycle N+1; out_valid rises the cycle after the edge where div_done is sampled, plus one DELIVER cycle.
- Divide-by-zero latency: out_valid high in cycle N+2.
- Reset mid-operation: everything returns to reset values immediately; a pending result is lost. A div_done arriving after reset is ignored (state is IDLE).
- Widths: no arithmetic beyond the counter, which is $clog2(TIMEOUT_CYC) bits wide and saturates and clears in LAUNCH.

Test Plan:
- WIDTH=4; request 13/3, divider model returns done after 10 cycles with q=4, r=1 -> one div_go pulse; out_valid with out_q=4, out_r=1, out_err=00; busy low after DELIVER.
- Request 7/0 -> div_go never asserts; out_q=15, out_r=7, out_err=01; out_valid two cycles after accept.
- TIMEOUT_CYC=16, model never asserts done -> div_abort single pulse after 16 WAIT cycles; out_err=10, out_q=0, out_r=0.
- Model asserts done 3 cycles after the abort -> ignored; out_valid count stays at one.
- out_ready=0; requests 9/2 then 8/4 -> first result (4,1) held stable; second completes and waits in DELIVER with in_ready=0. Raise out_ready -> results delivered in order: (4,1), then (2,0). No loss, no duplicate.
- Assert rst=0 mid-WAIT for 1 cycle (asynchronous, between edges) -> outputs zero immediately and in_ready=1. A later div_done produces no out_valid. A fresh 6/3 returns (2,0).
